mul_issuer: RTL and testbench

- Initiator side of the multiplier drdy handshake.
- Accepts operand pairs from an upstream valid/ready channel and drives p1/p2 with a single-cycle drdy_i pulse into the masked multiplier.
- Waits for drdy_o, captures out, and returns it on a downstream valid/ready channel.
- Owns the LFSR that produces the multiplier's random_vect, so every operation gets fresh masking randomness.

---
 rtl/mul_issuer.sv | 177 +++++++++++++++++
 tb/tb_mul_issuer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issuer.sv
// ============================================================================
// Module   : mul_issuer
// Purpose  : Initiator side of the masked-multiplier drdy handshake. Issues one
//            operand pair at a time, supplies fresh LFSR randomness per
//            operation and returns the product (or a timeout abort).
//            Optional counters: define MUL_ISSUER_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_issuer #(
  parameter int STATE_W = 128,
  parameter int RAND_W  = 8,
  parameter int RAND_N  = 10,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [STATE_W-1:0]        req_a,
  input  logic [STATE_W-1:0]        req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [STATE_W-1:0]        rsp_data,
  output logic                      rsp_err,
  output logic                      mul_drdy_i,
  output logic [STATE_W-1:0]        mul_p1,
  output logic [STATE_W-1:0]        mul_p2,
  input  logic                      mul_drdy_o,
  input  logic [STATE_W-1:0]        mul_out,
  input  logic                      seed_load,
  input  logic [RAND_N*RAND_W-1:0]  seed,
`ifdef MUL_ISSUER_STATS_EN
  output logic [31:0]               ops_done,
  output logic [15:0]               timeouts,
`endif
  output logic [RAND_N*RAND_W-1:0]  random_vect
);

  localparam int LFSR_W = RAND_N * RAND_W;
  localparam int CNT_W  = $clog2(TIMEOUT) + 1;
  localparam logic [LFSR_W-1:0] LFSR_ONE  = LFSR_W'(1);
  // x^80+x^79+x^43+x^42+1 for the default 80-bit width; top bit set keeps it nonzero
  localparam logic [LFSR_W-1:0] LFSR_TAPS = (LFSR_ONE << (LFSR_W-1)) | (LFSR_ONE << (LFSR_W-2)) |
                                            (LFSR_ONE << (LFSR_W/2+2)) | (LFSR_ONE << (LFSR_W/2+1));
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                ready_en_q;
  logic [STATE_W-1:0]  p1_q, p1_d, p2_q, p2_d;
  logic [STATE_W-1:0]  data_q, data_d;
  logic                err_q, err_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d, lfsr_step;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_comb begin
    state_d    = state_q;
    p1_d       = p1_q;
    p2_d       = p2_q;
    data_d     = data_q;
    err_d      = err_q;
    lfsr_d     = lfsr_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    mul_drdy_i = 1'b0;
    lfsr_step  = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);

    case (state_q)
      S_IDLE: begin
        // A seed load pre-empts any request presented in the same cycle
        if (seed_load) begin
          lfsr_d = (seed == '0) ? LFSR_ONE : seed;
        end else if (ready_en_q) begin
          req_ready = 1'b1;
          if (req_valid) begin
            p1_d    = req_a;
            p2_d    = req_b;
            lfsr_d  = lfsr_step;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        mul_drdy_i = 1'b1;
        cnt_d      = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mul_drdy_o) begin
          data_d  = mul_out;
          err_d   = 1'b0;
          state_d = S_HOLD;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ready_en_q <= 1'b0;
      p1_q       <= '0;
      p2_q       <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      lfsr_q     <= LFSR_ONE;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      data_q     <= data_d;
      err_q      <= err_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef MUL_ISSUER_STATS_EN
  logic [31:0] ops_done_q, ops_done_d;
  logic [15:0] timeouts_q, timeouts_d;

  always_comb begin
    ops_done_d = ops_done_q;
    timeouts_d = timeouts_q;
    if (state_q == S_HOLD && rsp_ready) begin
      if (err_q) begin
        if (timeouts_q != '1) timeouts_d = timeouts_q + 1'b1;
      end else begin
        if (ops_done_q != '1) ops_done_d = ops_done_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ops_done_q <= '0;
      timeouts_q <= '0;
    end else begin
      ops_done_q <= ops_done_d;
      timeouts_q <= timeouts_d;
    end
  end

  assign ops_done = ops_done_q;
  assign timeouts = timeouts_q;
`endif

  assign mul_p1      = p1_q;
  assign mul_p2      = p2_q;
  assign rsp_data    = data_q;
  assign rsp_err     = err_q;
  assign random_vect = lfsr_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_issuer.sv
// ============================================================================
// Module   : tb_mul_issuer
// Purpose  : Scoreboard bench for mul_issuer with a behavioural multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_issuer;

  localparam int STATE_W = 128;
  localparam int RAND_W  = 8;
  localparam int RAND_N  = 10;
  localparam int TIMEOUT = 64;
  localparam int LFSR_W  = RAND_N * RAND_W;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic [STATE_W-1:0]  req_a = '0;
  logic [STATE_W-1:0]  req_b = '0;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [STATE_W-1:0]  rsp_data;
  logic                rsp_err;
  logic                mul_drdy_i;
  logic [STATE_W-1:0]  mul_p1;
  logic [STATE_W-1:0]  mul_p2;
  logic                mul_drdy_o = 1'b0;
  logic [STATE_W-1:0]  mul_out = '0;
  logic                seed_load = 1'b0;
  logic [LFSR_W-1:0]   seed = '0;
  logic [LFSR_W-1:0]   random_vect;
`ifdef MUL_ISSUER_STATS_EN
  logic [31:0]         ops_done;
  logic [15:0]         timeouts;
`endif

  mul_issuer #(
    .STATE_W(STATE_W), .RAND_W(RAND_W), .RAND_N(RAND_N), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mul_drdy_i(mul_drdy_i), .mul_p1(mul_p1), .mul_p2(mul_p2),
    .mul_drdy_o(mul_drdy_o), .mul_out(mul_out),
    .seed_load(seed_load), .seed(seed),
`ifdef MUL_ISSUER_STATS_EN
    .ops_done(ops_done), .timeouts(timeouts),
`endif
    .random_vect(random_vect)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [STATE_W-1:0] data;
    logic               err;
    int                 lat;
  } exp_t;

  exp_t               sb[$];
  int                 n_tests = 0;
  int                 n_fail  = 0;
  int                 cyc     = 0;
  int                 model_delay = 5;
  logic [STATE_W-1:0] model_out = '0;
  logic [STATE_W-1:0] cur_a = '0, cur_b = '0;
  logic [LFSR_W-1:0]  rv_pulse = '0;

  task automatic check(input string tag, input logic [STATE_W-1:0] obs, input logic [STATE_W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural multiplier: answers model_delay cycles after the start pulse (never if negative)
  initial forever begin
    @(negedge clk);
    if (mul_drdy_i) begin
      rv_pulse = random_vect;
      check("p1_at_pulse", mul_p1, cur_a);
      check("p2_at_pulse", mul_p2, cur_b);
      if (model_delay >= 0) begin
        repeat (model_delay) @(posedge clk);
        #1;
        check("rv_stable", STATE_W'(random_vect), STATE_W'(rv_pulse));
        check("p1_stable", mul_p1, cur_a);
        mul_out    = model_out;
        mul_drdy_o = 1'b1;
        @(posedge clk);
        #1;
        mul_drdy_o = 1'b0;
        mul_out    = '0;
      end
    end
  end

  // Response monitor: pulse width, drdy_i-to-rsp_valid latency and scoreboard
  initial begin : monitor
    logic prev_drdy, prev_valid;
    int   t_pulse, lat_seen;
    exp_t e;
    prev_drdy = 1'b0; prev_valid = 1'b0; t_pulse = 0; lat_seen = 0;
    forever begin
      @(negedge clk);
      if (mul_drdy_i) begin
        check("drdy_i_width", STATE_W'(prev_drdy), '0);
        t_pulse = cyc;
      end
      prev_drdy = mul_drdy_i;
      if (rsp_valid && !prev_valid) lat_seen = cyc - t_pulse;
      prev_valid = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", STATE_W'(sb.size()), STATE_W'(1));
        end else begin
          e = sb.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("rsp_err", STATE_W'(rsp_err), STATE_W'(e.err));
          check("rsp_latency", STATE_W'(lat_seen), STATE_W'(e.lat));
        end
      end
    end
  end

  task automatic issue(input logic [STATE_W-1:0] a, input logic [STATE_W-1:0] b,
                       input logic [STATE_W-1:0] prod, input int delay);
    int   n;
    exp_t e;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("req_ready_wait", STATE_W'(req_ready), STATE_W'(1));
    model_delay = delay;
    model_out   = prod;
    cur_a = a; cur_b = b;
    e.data = (delay >= 0 && delay < TIMEOUT) ? prod : '0;
    e.err  = !(delay >= 0 && delay < TIMEOUT);
    e.lat  = e.err ? TIMEOUT : delay + 1;
    sb.push_back(e);
    req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(input int hold);
    int                 n;
    logic [STATE_W-1:0] d0;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!rsp_valid && n < 300);
    if (!rsp_valid) begin
      check("rsp_wait", STATE_W'(rsp_valid), STATE_W'(1));
      return;
    end
    d0 = rsp_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_data_stable", rsp_data, d0);
      check("bp_req_ready", STATE_W'(req_ready), '0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("idle_after_accept", STATE_W'(req_ready), STATE_W'(1));
  endtask

  initial begin : main
    logic [LFSR_W-1:0] prev_rv;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", STATE_W'(req_ready), '0);
    check("rst_rsp_valid", STATE_W'(rsp_valid), '0);
    check("rst_drdy_i", STATE_W'(mul_drdy_i), '0);
    check("rst_p1", mul_p1, '0);
    check("rst_rsp_data", rsp_data, '0);
    check("rst_lfsr", STATE_W'(random_vect), STATE_W'(1));
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("ready_after_rst", STATE_W'(req_ready), STATE_W'(1));

    // Basic op, then backpressure, timeout and drdy_o on the timeout cycle
    issue({16{8'h01}}, {16{8'h02}}, {8{16'hABCD}}, 5);
    get_rsp(0);
    issue({4{32'h1234_5678}}, {4{32'h9ABC_DEF0}}, {4{32'hCAFE_F00D}}, 3);
    get_rsp(10);
    issue({16{8'h33}}, {16{8'h44}}, {8{16'h5555}}, -1);
    get_rsp(0);
    issue({16{8'h55}}, {16{8'h66}}, {8{16'h7E57}}, TIMEOUT - 1);
    get_rsp(0);

    // Seed load beats a simultaneous request; zero seed becomes 1
    @(posedge clk); #1;
    seed = '0; seed_load = 1'b1; req_valid = 1'b1; req_a = '1; req_b = '1;
    @(negedge clk);
    check("seed_blocks_ready", STATE_W'(req_ready), '0);
    @(posedge clk); #1 seed_load = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("seed_no_issue", STATE_W'(mul_drdy_i), '0);
    check("seed_zero_to_one", STATE_W'(random_vect), STATE_W'(1));
    prev_rv = random_vect;
    for (int k = 0; k < 3; k++) begin
      issue(STATE_W'(k + 7), STATE_W'(k * 3 + 1), STATE_W'(k + 100), 2);
      get_rsp(0);
      check("rv_differs", STATE_W'(rv_pulse != prev_rv), STATE_W'(1));
      check("rv_nonzero", STATE_W'(rv_pulse != '0), STATE_W'(1));
      prev_rv = rv_pulse;
    end

    // Stray drdy_o while idle
    @(posedge clk); #1 mul_drdy_o = 1'b1; mul_out = '1;
    @(posedge clk); #1 mul_drdy_o = 1'b0; mul_out = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_no_rsp", STATE_W'(rsp_valid), '0);
    end

    // Asynchronous reset in the middle of WAIT
    issue({16{8'hA5}}, {16{8'h5A}}, {8{16'h1111}}, -1);
    repeat (10) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("mid_rst_drdy_i", STATE_W'(mul_drdy_i), '0);
    check("mid_rst_req_ready", STATE_W'(req_ready), '0);
    check("mid_rst_rsp_valid", STATE_W'(rsp_valid), '0);
    check("mid_rst_p1", mul_p1, '0);
    check("mid_rst_p2", mul_p2, '0);
    check("mid_rst_lfsr", STATE_W'(random_vect), STATE_W'(1));
    sb.delete();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 mul_drdy_o = 1'b1; mul_out = '1;
    @(posedge clk); #1 mul_drdy_o = 1'b0; mul_out = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("late_drdy_no_rsp", STATE_W'(rsp_valid), '0);
    end

    issue({16{8'h0F}}, {16{8'hF0}}, {8{16'hBEEF}}, 1);
    get_rsp(0);
    check("sb_drained", STATE_W'(sb.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
